// File: rtl/simple_processor_param.sv
`default_nettype none
// =============================================================================
// simple_processor_param: multicycle register-file core with a run/done handshake.
// Optional status flags are enabled by the SIMPLE_PROCESSOR_FLAGS_EN macro.
// Revision: 1.0
// =============================================================================
module simple_processor_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              run,
  input  logic [15:0]       DIN,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              done
`ifdef SIMPLE_PROCESSOR_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_T1   = 2'd1;
  localparam logic [1:0] S_T2   = 2'd2;
  localparam logic [1:0] S_T3   = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic [1:0]        state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [2:0]        opcode, rx, ry;
  logic              m_imm;
  logic [8:0]        imm9;
  logic              is_alu;
  logic [DATA_W-1:0] rx_val, ry_val, operand, alu_res, wr_data;
  logic              wr_en;

  assign opcode  = ir_q[15:13];
  assign m_imm   = ir_q[12];
  assign rx      = ir_q[11:9];
  assign ry      = ir_q[2:0];
  assign imm9    = ir_q[8:0];
  assign is_alu  = (opcode != OP_MV) && (opcode != OP_MVT) && (opcode != OP_NOP);
  assign operand = m_imm ? {{(DATA_W-9){1'b0}}, imm9} : ry_val;

  // Indices at or above NUM_REGS match no entry, so they read as zero.
  always_comb begin : read_mux
    rx_val   = '0;
    ry_val   = '0;
    dbg_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx == i[2:0])      rx_val   = regs_q[i];
      if (ry == i[2:0])      ry_val   = regs_q[i];
      if (dbg_sel == i[2:0]) dbg_data = regs_q[i];
    end
  end

  always_comb begin : alu
    case (opcode)
      OP_ADD:  alu_res = a_q + operand;
      OP_SUB:  alu_res = a_q - operand;
      OP_AND:  alu_res = a_q & operand;
      OP_OR:   alu_res = a_q | operand;
      OP_XOR:  alu_res = a_q ^ operand;
      default: alu_res = '0;
    endcase
  end

  always_comb begin : next_state
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          ir_d    = DIN;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (is_alu) begin
          a_d     = rx_val;
          state_d = S_T2;
        end else begin
          wr_en   = (opcode == OP_MV) || (opcode == OP_MVT);
          wr_data = (opcode == OP_MVT) ? {imm9[7:0], {(DATA_W-8){1'b0}}} : operand;
          state_d = S_IDLE;
        end
      end
      S_T2: begin
        g_d     = alu_res;
        state_d = S_T3;
      end
      default: begin
        wr_en   = 1'b1;
        wr_data = g_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin : reg_write
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (rx == i[2:0])) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = ((state_q == S_T1) && !is_alu) || (state_q == S_T3);

`ifdef SIMPLE_PROCESSOR_FLAGS_EN
  // Carry is resolved in T2 while A and the operand are still valid, then published in T3.
  logic c_pend_q, c_pend_d;
  logic flag_z_q, flag_z_d;
  logic flag_n_q, flag_n_d;
  logic flag_c_q, flag_c_d;

  always_comb begin : flag_next
    c_pend_d = c_pend_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_c_d = flag_c_q;
    if (state_q == S_T2) begin
      case (opcode)
        OP_ADD:  c_pend_d = (alu_res < a_q);
        OP_SUB:  c_pend_d = (a_q >= operand);
        default: c_pend_d = 1'b0;
      endcase
    end
    if (state_q == S_T3) begin
      flag_z_d = (g_q == '0);
      flag_n_d = g_q[DATA_W-1];
      flag_c_d = c_pend_q;
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      c_pend_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      c_pend_q <= c_pend_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign flag_c = flag_c_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_processor_param.sv
`default_nettype none
// Scoreboard bench for simple_processor_param: directed program, mid-op reset, random instructions.
module tb_simple_processor_param;
  localparam int DW = 16;
  localparam int NR = 6;

  logic          clk_50MHz = 1'b0;
  logic          reset_n;
  logic          run;
  logic [15:0]   DIN;
  logic [2:0]    dbg_sel;
  logic [DW-1:0] dbg_data;
  logic          busy, done;
`ifdef SIMPLE_PROCESSOR_FLAGS_EN
  logic          flag_z, flag_n, flag_c;
`endif

  always #10 clk_50MHz = ~clk_50MHz;

  simple_processor_param #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk_50MHz(clk_50MHz),
    .reset_n  (reset_n),
    .run      (run),
    .DIN      (DIN),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .busy     (busy),
    .done     (done)
`ifdef SIMPLE_PROCESSOR_FLAGS_EN
    ,
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c)
`endif
  );

  typedef struct {
    int               lat;
    int               cap;
    logic [8*DW-1:0]  snap;
    logic             z, n, c;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_regs [8];
  logic          mz, mn, mc;
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] mrd(input logic [2:0] idx);
    return (int'(idx) < NR) ? m_regs[idx] : '0;
  endfunction

  function automatic logic [8*DW-1:0] model_snap();
    logic [8*DW-1:0] s;
    for (int i = 0; i < 8; i++) s[i*DW +: DW] = mrd(3'(i));
    return s;
  endfunction

  task automatic sweep(input string name, input logic [8*DW-1:0] snap);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      chk($sformatf("%s r%0d", name, i), 64'(dbg_data), 64'(snap[i*DW +: DW]));
    end
  endtask

  // Reference model: apply one instruction to the architectural state and queue the expectation.
  task automatic model_push(input logic [15:0] ins);
    exp_t       e;
    logic [2:0] op, rx;
    longint     a, b, r, mask;
    mask = (longint'(1) << DW) - 1;
    op   = ins[15:13];
    rx   = ins[11:9];
    b    = ins[12] ? longint'(ins[8:0]) : longint'(mrd(ins[2:0]));
    a    = longint'(mrd(rx));
    case (op)
      3'd0:    r = b;
      3'd1:    r = longint'(ins[7:0]) << (DW - 8);
      3'd2:    r = a + b;
      3'd3:    r = a - b;
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      3'd6:    r = a ^ b;
      default: r = 0;
    endcase
    r = r & mask;
    if (op != 3'd7 && int'(rx) < NR) m_regs[rx] = r[DW-1:0];
    e.lat = (op >= 3'd2 && op <= 3'd6) ? 3 : 1;
    if (e.lat == 3) begin
      mz = (r == 0);
      mn = r[DW-1];
      mc = (op == 3'd2) ? ((a + b) > mask) : (op == 3'd3) ? (a >= b) : 1'b0;
    end
    e.cap  = cyc;
    e.snap = model_snap();
    e.z    = mz;
    e.n    = mn;
    e.c    = mc;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    mz = 1'b0;
    mn = 1'b0;
    mc = 1'b0;
  endtask

  // While busy, run and DIN toggle randomly; the core must ignore them.
  task automatic wait_idle();
    int guard = 0;
    while (busy) begin
      run = 1'($urandom_range(0, 1));
      DIN = 16'($urandom);
      @(negedge clk_50MHz);
      guard++;
      if (guard > 10) begin
        checks++;
        failures++;
        $display("FAIL idle wait: busy still 1 after %0d cycles, required 0", guard);
        return;
      end
    end
  endtask

  task automatic issue(input logic [15:0] ins);
    wait_idle();
    run = 1'b1;
    DIN = ins;
    model_push(ins);
    @(negedge clk_50MHz);
    run = 1'($urandom_range(0, 1));
    DIN = 16'($urandom);
  endtask

  task automatic gap(input int n);
    wait_idle();
    run = 1'b0;
    repeat (n) @(negedge clk_50MHz);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_50MHz);
      if (reset_n === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious done: done=1 with no instruction outstanding, required 0");
        end else begin
          e = sb.pop_front();
          chk("done latency", 64'(cyc - e.cap), 64'(e.lat));
          @(negedge clk_50MHz);
          sweep("regs", e.snap);
`ifdef SIMPLE_PROCESSOR_FLAGS_EN
          chk("flag_z", 64'(flag_z), 64'(e.z));
          chk("flag_n", 64'(flag_n), 64'(e.n));
          chk("flag_c", 64'(flag_c), 64'(e.c));
`endif
        end
      end
    end
  end

  initial begin : stimulus
    int g;
    reset_n = 1'b0;
    run     = 1'b0;
    DIN     = 16'h0000;
    dbg_sel = 3'd0;
    model_reset();
    repeat (3) @(negedge clk_50MHz);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    sweep("reset", model_snap());
    reset_n = 1'b1;
    @(negedge clk_50MHz);

    // Directed program: mv, mvt, add wrap, sub borrow, out-of-range regs, rX==rY.
    issue(16'h101C);
    issue(16'h0200);
    issue(16'h32FF);
    issue(16'h52FF);
    issue(16'h5201);
    issue(16'h1405);
    issue(16'h7407);
    issue(16'h1C09);
    issue(16'h0006);
    issue(16'h1660);
    issue(16'h4603);
    issue(16'hE000);
    gap(2);

    // Reset landing in T2 of an add.
    issue(16'h5201);
    run = 1'b0;
    @(posedge clk_50MHz);
    #5;
    chk("busy in T2", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("busy after async reset", 64'(busy), 64'd0);
    chk("done after async reset", 64'(done), 64'd0);
    sb.delete();
    model_reset();
    @(negedge clk_50MHz);
    sweep("mid-op reset", model_snap());
`ifdef SIMPLE_PROCESSOR_FLAGS_EN
    chk("flags after reset", 64'({flag_z, flag_n, flag_c}), 64'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk_50MHz);

    repeat (200) begin
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      issue(16'($urandom));
    end

    gap(4);
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk_50MHz);
      g++;
    end
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk_50MHz);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
